adc_channel_averager: RTL and testbench

ADC_CHANNEL_AVERAGER -- requirements
Module: adc_channel_averager

---
 rtl/adc_avg_pkg.sv | 15 +
 rtl/adc_avg_lane.sv | 77 +++++++
 rtl/adc_channel_averager.sv | 163 ++++++++++++++++
 tb/tb_adc_channel_averager.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_avg_pkg.sv
// -----------------------------------------------------------------------------
// adc_avg_pkg
// Shared constants for the ADC channel averager: CSR data width and the bit
// positions of the status word and the per-channel "new" flag.
// -----------------------------------------------------------------------------
package adc_avg_pkg;

    localparam int CSR_DW          = 32;  // CSR read/write data width
    localparam int NEW_BIT         = 31;  // "new result" flag in channel words
    localparam int FCNT_W          = 16;  // frame counter width (bits 15:0)
    localparam int ST_CH_ERR_BIT   = 16;  // sticky: sample on a non-existent channel
    localparam int ST_SEQ_ERR_BIT  = 17;  // sticky: start-of-packet inside a frame
    localparam int ST_IN_FRAME_BIT = 18;  // live: currently between sop and eop

endpackage

// File: rtl/adc_avg_lane.sv
// -----------------------------------------------------------------------------
// adc_avg_lane
// One channel of the averager: accumulates 2^AVG_LOG2 samples, then latches the
// truncated mean into the result register and raises the "new" flag.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   i_smp_vld     : a sample for this channel is accepted this cycle
//   i_smp_data    : sample value (unsigned)
//   i_clr_new     : CSR read of this channel, clears the "new" flag
//   o_done        : this cycle's sample completes an average (combinational)
//   o_avg         : the average being completed (combinational)
//   o_result      : last completed average
//   o_new         : "new" flag
// -----------------------------------------------------------------------------
module adc_avg_lane #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_smp_vld,
    input  logic [DATA_W-1:0] i_smp_data,
    input  logic              i_clr_new,
    output logic              o_done,
    output logic [DATA_W-1:0] o_avg,
    output logic [DATA_W-1:0] o_result,
    output logic              o_new
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 1) ? AVG_LOG2 : 1;
    localparam int LAST  = (1 << AVG_LOG2) - 1;

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_result;
    logic              r_new;

    logic [ACC_W-1:0]  w_sum;
    logic              w_last;

    // The accumulator holds at most 2^AVG_LOG2-1 samples, so adding the final
    // one still fits in ACC_W bits and the shift needs no extra headroom.
    assign w_sum  = r_acc + ACC_W'(i_smp_data);
    assign w_last = (r_cnt == CNT_W'(LAST));
    assign o_done = i_smp_vld && w_last;
    assign o_avg  = w_sum[ACC_W-1:AVG_LOG2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (i_smp_vld) begin
            if (w_last) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_result <= o_avg;
            end else begin
                r_acc    <= w_sum;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Completion beats a same-cycle CSR read so a fresh result is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_new <= 1'b0;
        else if (o_done)    r_new <= 1'b1;
        else if (i_clr_new) r_new <= 1'b0;
    end

    assign o_result = r_result;
    assign o_new    = r_new;

endmodule

// File: rtl/adc_channel_averager.sv
// -----------------------------------------------------------------------------
// adc_channel_averager
// Averages an ADC sequencer response stream per channel and exposes results and
// frame/status information through a small CSR window.
//
// Ports
//   clk_clk, reset_reset          : clock, asynchronous active-high reset
//   response_valid/channel/data   : incoming sample stream
//   response_startofpacket/endofpacket : sequencer frame markers
//   avg_valid/channel/data        : registered completion pulse + result
//   csr_address/read/write/writedata/readdata : CSR port; addresses
//                                   0..NUM_CH-1 are channel results, NUM_CH is
//                                   status (frame count, ch_err, seq_err, in_frame)
// -----------------------------------------------------------------------------
module adc_channel_averager
    import adc_avg_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 12,
    parameter int CH_W     = 5,
    parameter int AVG_LOG2 = 2,
    localparam int AW      = $clog2(NUM_CH + 1)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              response_valid,
    input  logic [CH_W-1:0]   response_channel,
    input  logic [DATA_W-1:0] response_data,
    input  logic              response_startofpacket,
    input  logic              response_endofpacket,
    output logic              avg_valid,
    output logic [CH_W-1:0]   avg_channel,
    output logic [DATA_W-1:0] avg_data,
    input  logic [AW-1:0]     csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [CSR_DW-1:0] csr_writedata,
    output logic [CSR_DW-1:0] csr_readdata
);

    logic                           w_accept;
    logic                           w_bad_ch;
    logic                           w_sop;
    logic                           w_eop;
    logic                           w_stat_sel;
    logic                           w_stat_wr;
    logic [NUM_CH-1:0]              w_done;
    logic [NUM_CH-1:0]              w_new;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_avg;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_result;
    logic [DATA_W-1:0]              w_done_avg;
    logic [CSR_DW-1:0]              w_rdata;

    logic                           r_avg_valid;
    logic [CH_W-1:0]                r_avg_channel;
    logic [DATA_W-1:0]              r_avg_data;
    logic [FCNT_W-1:0]              r_frame_cnt;
    logic                           r_in_frame;
    logic                           r_ch_err;
    logic                           r_seq_err;
    logic [CSR_DW-1:0]              r_csr_rdata;

    assign w_accept   = response_valid && (int'(response_channel) < NUM_CH);
    assign w_bad_ch   = response_valid && !w_accept;
    assign w_sop      = response_valid && response_startofpacket;
    assign w_eop      = response_valid && response_endofpacket;
    assign w_stat_sel = (csr_address == AW'(NUM_CH));
    assign w_stat_wr  = csr_write && w_stat_sel;

    // Only the status word's W1C bits are meaningful on writes.
    wire w_unused_wdata = &{1'b0, csr_writedata};

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            adc_avg_lane #(
                .DATA_W   (DATA_W),
                .AVG_LOG2 (AVG_LOG2)
            ) u_lane (
                .clk        (clk_clk),
                .rst        (reset_reset),
                .i_smp_vld  (w_accept && (response_channel == CH_W'(g))),
                .i_smp_data (response_data),
                .i_clr_new  (csr_read && (csr_address == AW'(g))),
                .o_done     (w_done[g]),
                .o_avg      (w_avg[g]),
                .o_result   (w_result[g]),
                .o_new      (w_new[g])
            );
        end
    endgenerate

    // At most one lane completes per cycle, so an AND-OR mux is enough.
    always_comb begin
        w_done_avg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_done[i]) w_done_avg = w_done_avg | w_avg[i];
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_avg_valid   <= 1'b0;
            r_avg_channel <= '0;
            r_avg_data    <= '0;
        end else begin
            r_avg_valid <= |w_done;
            if (|w_done) begin
                r_avg_channel <= response_channel;
                r_avg_data    <= w_done_avg;
            end
        end
    end

    // Frame tracking: eop dominates, so a sop+eop cycle is a whole frame.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_frame_cnt <= '0;
            r_in_frame  <= 1'b0;
            r_ch_err    <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_frame_cnt <= r_frame_cnt + FCNT_W'(w_eop);
            if (w_eop)      r_in_frame <= 1'b0;
            else if (w_sop) r_in_frame <= 1'b1;
            // Sticky errors: a new error event wins over a W1C in the same cycle.
            r_ch_err  <= w_bad_ch ||
                         (r_ch_err && !(w_stat_wr && csr_writedata[ST_CH_ERR_BIT]));
            r_seq_err <= (w_sop && r_in_frame) ||
                         (r_seq_err && !(w_stat_wr && csr_writedata[ST_SEQ_ERR_BIT]));
        end
    end

    // Read mux samples pre-update state, so a read coinciding with a completion
    // returns the old flag/result.
    always_comb begin
        w_rdata = '0;
        if (w_stat_sel) begin
            w_rdata[FCNT_W-1:0]      = r_frame_cnt;
            w_rdata[ST_CH_ERR_BIT]   = r_ch_err;
            w_rdata[ST_SEQ_ERR_BIT]  = r_seq_err;
            w_rdata[ST_IN_FRAME_BIT] = r_in_frame;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (csr_address == AW'(i)) begin
                    w_rdata[NEW_BIT]      = w_new[i];
                    w_rdata[DATA_W-1:0]   = w_result[i];
                end
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)   r_csr_rdata <= '0;
        else if (csr_read) r_csr_rdata <= w_rdata;
    end

    assign avg_valid    = r_avg_valid;
    assign avg_channel  = r_avg_channel;
    assign avg_data     = r_avg_data;
    assign csr_readdata = r_csr_rdata;

endmodule

// File: tb/tb_adc_channel_averager.sv
module tb_adc_channel_averager;

    localparam int NUM_CH   = 8;
    localparam int DATA_W   = 12;
    localparam int CH_W     = 5;
    localparam int AVG_LOG2 = 2;
    localparam int AW       = $clog2(NUM_CH + 1);
    localparam int BLK      = 1 << AVG_LOG2;

    logic              clk_clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic              response_valid = 1'b0;
    logic [CH_W-1:0]   response_channel = '0;
    logic [DATA_W-1:0] response_data = '0;
    logic              response_startofpacket = 1'b0;
    logic              response_endofpacket = 1'b0;
    logic              avg_valid;
    logic [CH_W-1:0]   avg_channel;
    logic [DATA_W-1:0] avg_data;
    logic [AW-1:0]     csr_address = '0;
    logic              csr_read = 1'b0;
    logic              csr_write = 1'b0;
    logic [31:0]       csr_writedata = '0;
    logic [31:0]       csr_readdata;

    adc_channel_averager #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .response_valid(response_valid), .response_channel(response_channel),
        .response_data(response_data),
        .response_startofpacket(response_startofpacket),
        .response_endofpacket(response_endofpacket),
        .avg_valid(avg_valid), .avg_channel(avg_channel), .avg_data(avg_data),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
    );

    always #5 clk_clk = ~clk_clk;

    int cmp_n = 0;
    int err_n = 0;

    // ---------------- behavioural model ----------------
    int unsigned       m_sum [NUM_CH];
    int unsigned       m_cnt [NUM_CH];
    logic [DATA_W-1:0] m_res [NUM_CH];
    bit                m_new [NUM_CH];
    int unsigned       m_fcnt;
    bit                m_in_frame, m_ch_err, m_seq_err;
    bit                e_vld;
    logic [31:0]       e_ch, e_data, e_rd;
    bit                rd_chk = 1'b0;
    bit                chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_word();
        logic [31:0] s;
        s = 32'(m_fcnt & 32'hFFFF);
        s[16] = m_ch_err;
        s[17] = m_seq_err;
        s[18] = m_in_frame;
        return s;
    endfunction

    task automatic model_update(input bit rst, input bit v, input int ch, input int data,
                                input bit sop, input bit eop, input bit rd, input bit wr,
                                input int addr, input logic [31:0] wd);
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_res[i] = '0; m_new[i] = 0;
            end
            m_fcnt = 0; m_in_frame = 0; m_ch_err = 0; m_seq_err = 0;
            e_vld = 0; e_ch = 0; e_data = 0; e_rd = 0; rd_chk = 1;
            return;
        end
        // reads see the state from before this cycle's events
        rd_chk = rd;
        if (rd) begin
            if (addr < NUM_CH) begin
                e_rd = 32'(m_res[addr]);
                e_rd[31] = m_new[addr];
            end else if (addr == NUM_CH) e_rd = status_word();
            else e_rd = 0;
        end
        // clears first, so that sets applied afterwards win
        if (rd && addr < NUM_CH) m_new[addr] = 0;
        if (wr && addr == NUM_CH) begin
            if (wd[16]) m_ch_err = 0;
            if (wd[17]) m_seq_err = 0;
        end
        e_vld = 0;
        if (v) begin
            if (ch < NUM_CH) begin
                m_sum[ch] += data;
                m_cnt[ch] += 1;
                if (m_cnt[ch] == BLK) begin
                    m_res[ch] = DATA_W'(m_sum[ch] / BLK);
                    m_new[ch] = 1;
                    m_sum[ch] = 0; m_cnt[ch] = 0;
                    e_vld = 1; e_ch = ch; e_data = 32'(m_res[ch]);
                end
            end else m_ch_err = 1;
            if (sop && m_in_frame) m_seq_err = 1;
            if (eop) begin
                m_fcnt = (m_fcnt + 1) % 65536;
                m_in_frame = 0;
            end else if (sop) m_in_frame = 1;
        end
    endtask

    // the one compare process: every cycle once the model is live
    always @(negedge clk_clk) begin
        if (chk_en) begin
            chk("avg_valid", 32'(avg_valid), 32'(e_vld));
            chk("avg_channel", 32'(avg_channel), e_ch);
            chk("avg_data", 32'(avg_data), e_data);
            if (rd_chk) chk("csr_readdata", csr_readdata, e_rd);
        end
    end

    // one clock of stimulus; returns at negedge+1 with outputs settled
    task automatic step(input bit rst, input bit v, input int ch, input int data,
                        input bit sop, input bit eop, input bit rd, input bit wr,
                        input int addr, input logic [31:0] wd);
        reset_reset            = rst;
        response_valid         = v;
        response_channel       = ch[CH_W-1:0];
        response_data          = data[DATA_W-1:0];
        response_startofpacket = sop;
        response_endofpacket   = eop;
        csr_read               = rd;
        csr_write              = wr;
        csr_address            = addr[AW-1:0];
        csr_writedata          = wd;
        @(posedge clk_clk);
        model_update(rst, v, ch, data, sop, eop, rd, wr, addr, wd);
        @(negedge clk_clk);
        #1;
    endtask

    task automatic smp(input int ch, input int data);
        step(0, 1, ch, data, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic frm(input int ch, input int data, input bit sop, input bit eop);
        step(0, 1, ch, data, sop, eop, 0, 0, 0, 0);
    endtask
    task automatic rd(input int addr);
        step(0, 0, 0, 0, 0, 0, 1, 0, addr, 0);
    endtask
    task automatic wr(input int addr, input logic [31:0] wd);
        step(0, 0, 0, 0, 0, 0, 0, 1, addr, wd);
    endtask
    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
    endtask

    initial begin
        int ch, data, addr;
        bit v, sop, eop, r, w, rs;
        logic [31:0] wd;

        do_reset();
        chk_en = 1'b1;
        // reset state
        chk("rst_avg_valid", 32'(avg_valid), 32'd0);
        chk("rst_avg_data", 32'(avg_data), 32'd0);
        chk("rst_readdata", csr_readdata, 32'd0);
        rd(NUM_CH);
        chk("rst_status", csr_readdata, 32'h0);

        // 100,200,300,400 on ch3 -> 250, one cycle after the 4th sample
        smp(3, 100); smp(3, 200); smp(3, 300);
        chk("ch3_no_early_valid", 32'(avg_valid), 32'd0);
        smp(3, 400);
        chk("ch3_valid", 32'(avg_valid), 32'd1);
        chk("ch3_channel", 32'(avg_channel), 32'd3);
        chk("ch3_avg", 32'(avg_data), 32'd250);
        idle();
        chk("ch3_single_pulse", 32'(avg_valid), 32'd0);
        chk("ch3_avg_hold", 32'(avg_data), 32'd250);

        // full-scale samples do not overflow; read clears the new flag
        for (int i = 0; i < 4; i++) smp(5, 4095);
        chk("ch5_avg", 32'(avg_data), 32'd4095);
        rd(5);
        chk("ch5_read_new", csr_readdata, 32'h80000FFF);
        rd(5);
        chk("ch5_reread", csr_readdata, 32'h00000FFF);

        // out-of-range channel: dropped, ch_err set, W1C clears it
        smp(9, 77);
        chk("ch9_no_valid", 32'(avg_valid), 32'd0);
        rd(NUM_CH);
        chk("ch_err_set", csr_readdata & 32'h00010000, 32'h00010000);
        wr(NUM_CH, 32'h00010000);
        rd(NUM_CH);
        chk("ch_err_cleared", csr_readdata & 32'h00010000, 32'h0);

        // three frames, then sop, then a second sop
        do_reset();
        for (int f = 0; f < 3; f++) begin
            frm(0, 1, 1, 0); frm(1, 2, 0, 0); frm(2, 3, 0, 1);
        end
        frm(0, 1, 1, 0);
        frm(1, 1, 1, 0);
        rd(NUM_CH);
        chk("frame_status", csr_readdata, 32'h00060003);

        // sop+eop together is a whole frame and leaves in_frame clear
        do_reset();
        frm(4, 9, 1, 1);
        rd(NUM_CH);
        chk("one_sample_frame", csr_readdata, 32'h00000001);

        // reset mid-block discards the partial sum; check it is asynchronous
        do_reset();
        smp(0, 999); smp(0, 999);
        reset_reset = 1'b1;
        #1;
        chk("async_rst_readdata", csr_readdata, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        for (int i = 0; i < 4; i++) smp(0, 40);
        chk("post_reset_valid", 32'(avg_valid), 32'd1);
        chk("post_reset_avg", 32'(avg_data), 32'd40);

        // read coincides with completion: old flag returned, set wins
        do_reset();
        smp(2, 10); smp(2, 20); smp(2, 30);
        step(0, 1, 2, 40, 0, 0, 1, 0, 2, 0);
        chk("coincide_read_old", csr_readdata, 32'h00000000);
        chk("coincide_avg", 32'(avg_data), 32'd25);
        rd(2);
        chk("coincide_flag_kept", csr_readdata, 32'h80000019);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rs   = ($urandom_range(0, 299) == 0);
            v    = ($urandom_range(0, 3) != 0);
            ch   = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, NUM_CH - 1))
                                                : int'($urandom_range(NUM_CH, 31));
            data = ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(0, 4095));
            sop  = ($urandom_range(0, 5) == 0);
            eop  = ($urandom_range(0, 5) == 0);
            r    = ($urandom_range(0, 3) == 0);
            w    = ($urandom_range(0, 7) == 0);
            addr = ($urandom_range(0, 3) == 0) ? NUM_CH : int'($urandom_range(0, NUM_CH));
            wd   = $urandom;
            step(rs, v, ch, data, sop, eop, r, w, addr, wd);
        end

        // final sweep of all result registers and status
        for (int i = 0; i <= NUM_CH; i++) rd(i);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
